// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the ethernet MAC transmit/receive paths.
// Holds the transmit framer state encoding, the framing byte constants and
// the CRC-32 constants used by the FCS generator and checker.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SFD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAD   = 3'd4,
        ST_FCS   = 3'd5,
        ST_DRAIN = 3'd6,
        ST_IFG   = 3'd7
    } mac_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int          FCS_BYTES       = 4;

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational one-byte step of the IEEE 802.3 CRC-32 in its
// reflected form (LSB of the data byte enters first).
// Ports:
//   crc_in  [31:0] current CRC register value
//   data_in [7:0]  byte to fold in
//   crc_out [31:0] CRC register value after the byte
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: transmit MAC framer. Takes an LLC byte stream over a
// valid/ready/last handshake and drives GMII-style txen/txd/txer with
// preamble/SFD, zero padding, CRC-32 FCS, inter-frame gap and abort handling.
// Ports:
//   in_txc, in_rst_n           clock (rising edge), async active-low reset
//   in_valid/in_data/in_last   upstream byte stream
//   out_ready                  byte accepted when in_valid & out_ready
//   out_txen/out_txd/out_txer  registered GMII outputs
//   out_frame_done, out_abort  one-cycle status pulses
// Handshake: a byte transfers on a rising edge where in_valid and out_ready
// are both high; out_ready depends only on state, never on in_valid.
// Every output except out_ready is registered, so the wire shows the action
// decided in a given state one cycle later.
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int IFG_BYTES       = 12,
    parameter int FCS_EN          = 1
) (
    input  logic       in_txc,
    input  logic       in_rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_ready,
    output logic       out_txen,
    output logic [7:0] out_txd,
    output logic       out_txer,
    output logic       out_frame_done,
    output logic       out_abort
);

    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int IFG_W = $clog2(IFG_BYTES + 2);
    // Data+pad length target; FCS bytes are excluded from it when appended.
    localparam int PAD_INT = (MIN_FRAME_BYTES == 0) ? 0 :
                             (FCS_EN == 0) ? MIN_FRAME_BYTES :
                             (MIN_FRAME_BYTES > FCS_BYTES) ? MIN_FRAME_BYTES - FCS_BYTES : 0;
    localparam int MAX_INT = (FCS_EN == 0) ? MAX_FRAME_BYTES : MAX_FRAME_BYTES - FCS_BYTES;

    localparam logic [CNT_W-1:0] PAD_TARGET = CNT_W'(PAD_INT);
    localparam logic [CNT_W-1:0] DATA_MAX   = CNT_W'(MAX_INT);
    localparam logic [IFG_W-1:0] IFG_SAT    = IFG_W'(IFG_BYTES);
    localparam logic [3:0]       PRE_LAST   = 4'(PREAMBLE_BYTES - 1);

    mac_state_e       state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [1:0]       fcs_idx_q, fcs_idx_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d, ifg_cnt_inc;
    logic [31:0]      crc_q, crc_d, crc_next, crc_inv;
    logic [7:0]       crc_byte;
    logic             txen_q, txen_d, txer_q, txer_d;
    logic [7:0]       txd_q, txd_d;
    logic             done_q, done_d, abort_q, abort_d;
    logic             ifg_exit;

    // Only DATA feeds real bytes into the CRC; PAD feeds zeros.
    assign crc_byte = (state_q == ST_DATA) ? in_data : 8'h00;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );

    assign byte_cnt_inc = byte_cnt_q + CNT_W'(1);
    assign ifg_cnt_inc  = (ifg_cnt_q == IFG_SAT) ? ifg_cnt_q : ifg_cnt_q + IFG_W'(1);
    assign crc_inv      = ~crc_q;
    // The IDLE cycle that follows IFG is itself one more idle cycle on the
    // wire, so IFG can release one cycle early.
    assign ifg_exit     = (int'(ifg_cnt_q) + 2) >= IFG_BYTES;
    assign out_ready    = (state_q == ST_DATA) || (state_q == ST_DRAIN);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        fcs_idx_d  = fcs_idx_q;
        crc_d      = crc_q;
        ifg_cnt_d  = '0;
        txen_d     = 1'b0;
        txd_d      = 8'h00;
        txer_d     = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pre_cnt_d = '0;
                if (in_valid) state_d = ST_PRE;
            end
            ST_PRE: begin
                txen_d    = 1'b1;
                txd_d     = PREAMBLE_BYTE;
                pre_cnt_d = pre_cnt_q + 4'd1;
                if (pre_cnt_q == PRE_LAST) state_d = ST_SFD;
            end
            ST_SFD: begin
                txen_d     = 1'b1;
                txd_d      = SFD_BYTE;
                crc_d      = CRC32_INIT;
                byte_cnt_d = '0;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                txen_d = 1'b1;
                if (!in_valid || (byte_cnt_q == DATA_MAX)) begin
                    // Underrun, or a byte that would overflow the frame:
                    // flag the error on the wire and drop the rest.
                    txer_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = (in_valid && in_last) ? ST_IFG : ST_DRAIN;
                end else begin
                    txd_d      = in_data;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                    if (in_last) begin
                        if (byte_cnt_inc < PAD_TARGET) begin
                            state_d = ST_PAD;
                        end else if (FCS_EN != 0) begin
                            fcs_idx_d = '0;
                            state_d   = ST_FCS;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IFG;
                        end
                    end
                end
            end
            ST_PAD: begin
                txen_d     = 1'b1;
                crc_d      = crc_next;
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= PAD_TARGET) begin
                    if (FCS_EN != 0) begin
                        fcs_idx_d = '0;
                        state_d   = ST_FCS;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IFG;
                    end
                end
            end
            ST_FCS: begin
                txen_d    = 1'b1;
                txd_d     = crc_inv[{fcs_idx_q, 3'b000} +: 8];
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'd3) begin
                    done_d  = 1'b1;
                    state_d = ST_IFG;
                end
            end
            ST_DRAIN: begin
                // Drain cycles are idle on the wire, so they count as gap.
                ifg_cnt_d = ifg_cnt_inc;
                if (in_valid && in_last) state_d = ST_IFG;
            end
            ST_IFG: begin
                ifg_cnt_d = ifg_cnt_inc;
                if (ifg_exit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_txc or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            pre_cnt_q  <= '0;
            fcs_idx_q  <= '0;
            ifg_cnt_q  <= '0;
            crc_q      <= '0;
            txen_q     <= 1'b0;
            txd_q      <= 8'h00;
            txer_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            fcs_idx_q  <= fcs_idx_d;
            ifg_cnt_q  <= ifg_cnt_d;
            crc_q      <= crc_d;
            txen_q     <= txen_d;
            txd_q      <= txd_d;
            txer_q     <= txer_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign out_txen       = txen_q;
    assign out_txd        = txd_q;
    assign out_txer       = txer_q;
    assign out_frame_done = done_q;
    assign out_abort      = abort_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: directed bench for mac_tx_framer. Instance dut_a runs
// with padding disabled, dut_b with default parameters; sel routes the
// shared stimulus and the monitored outputs to one of them.
module tb_mac_tx_framer;

    localparam int PRE = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       in_valid, in_last;
    logic [7:0] in_data;

    logic       ready_a, txen_a, txer_a, done_a, abort_a;
    logic       ready_b, txen_b, txer_b, done_b, abort_b;
    logic [7:0] txd_a, txd_b;

    logic       mon_ready, mon_txen, mon_txer, mon_done, mon_abort;
    logic [7:0] mon_txd;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int hi_run = 0, low_run = 0, gap_last = 0;
    logic prev_txen = 1'b0;

    logic [8:0] exp_q[$];
    int         len_q[$];

    // ---------------- clock / reset / DUTs ----------------
    always #5 clk = ~clk;

    mac_tx_framer #(.MIN_FRAME_BYTES(0)) dut_a (
        .in_txc(clk), .in_rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_data(in_data), .in_last(in_last),
        .out_ready(ready_a), .out_txen(txen_a), .out_txd(txd_a), .out_txer(txer_a),
        .out_frame_done(done_a), .out_abort(abort_a)
    );

    mac_tx_framer dut_b (
        .in_txc(clk), .in_rst_n(rst_n),
        .in_valid(in_valid & sel), .in_data(in_data), .in_last(in_last),
        .out_ready(ready_b), .out_txen(txen_b), .out_txd(txd_b), .out_txer(txer_b),
        .out_frame_done(done_b), .out_abort(abort_b)
    );

    assign mon_ready = sel ? ready_b : ready_a;
    assign mon_txen  = sel ? txen_b  : txen_a;
    assign mon_txd   = sel ? txd_b   : txd_a;
    assign mon_txer  = sel ? txer_b  : txer_a;
    assign mon_done  = sel ? done_b  : done_a;
    assign mon_abort = sel ? abort_b : abort_a;

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent bitwise CRC-32 model (reflected, one data bit per step).
    function automatic logic [31:0] model_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Scoreboard feed: expected {txer, txd} for every txen-high cycle.
    task automatic push_frame(input logic [7:0] bytes[$], input int min_bytes,
                              input int stall_after, input bit lit_en,
                              input logic [31:0] lit_fcs);
        logic [31:0] crc, fcs;
        int target, n;
        for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        if (stall_after >= 0) begin
            for (int i = 0; i < stall_after; i++) exp_q.push_back({1'b0, bytes[i]});
            exp_q.push_back(9'h100);
            return;
        end
        crc = 32'hFFFFFFFF;
        foreach (bytes[i]) begin
            exp_q.push_back({1'b0, bytes[i]});
            crc = model_crc(crc, bytes[i]);
        end
        target = (min_bytes == 0) ? 0 : min_bytes - 4;
        n = bytes.size();
        while (n < target) begin
            exp_q.push_back(9'h000);
            crc = model_crc(crc, 8'h00);
            n++;
        end
        fcs = lit_en ? lit_fcs : ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
    endtask

    // ---------------- driver ----------------
    task automatic drive_frame(input logic [7:0] bytes[$], input int stall_after, input bit hold);
        int i = 0;
        int guard = 0;
        bit stalled = 1'b0;
        while (i < bytes.size() && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (stall_after >= 0 && !stalled && i == stall_after && mon_ready) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                stalled  = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_data  = bytes[i];
                in_last  = (i == bytes.size() - 1);
                if (mon_ready) i++;
            end
        end
        check("drive_timeout", 32'(guard < 5000), 32'd1);
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int k = 0; k < 3000 && quiet < 3; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_txen) quiet++;
            else quiet = 0;
        end
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_len(input string tag, input int exp_len);
        int obs;
        obs = (len_q.size() > 0) ? len_q.pop_front() : -1;
        check(tag, 32'(obs), 32'(exp_len));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run    = 0;
            low_run   = 0;
            prev_txen = 1'b0;
        end else begin
            if (mon_txen) begin
                if (!prev_txen) begin
                    gap_last = low_run;
                    hi_run   = 1;
                end else begin
                    hi_run++;
                end
                check("unexpected_txen", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("wire_byte", {23'd0, mon_txer, mon_txd}, {23'd0, exp_q.pop_front()});
            end else begin
                if (prev_txen) begin
                    len_q.push_back(hi_run);
                    low_run = 1;
                end else begin
                    low_run++;
                end
            end
            prev_txen = mon_txen;
            if (mon_done)  done_cnt++;
            if (mon_abort) abort_cnt++;
        end
    end

    // ---------------- directed sequence ----------------
    logic [7:0] f1[$], f2[$];

    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_a", {20'd0, txen_a, txd_a, txer_a, ready_a, done_a, abort_a}, 32'd0);
        check("reset_b", {20'd0, txen_b, txd_b, txer_b, ready_b, done_b, abort_b}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {30'd0, mon_txen, mon_ready}, 32'd0);

        // Check value "123456789", no padding.
        f1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_frame(f1, 0, -1, 1'b1, 32'hCBF43926);
        drive_frame(f1, -1, 1'b0);
        wait_idle("t1");
        check_len("t1_txen_len", 21);
        check("t1_done", 32'(done_cnt), 32'd1);

        // Defaults from here on.
        sel = 1'b1;
        repeat (3) @(negedge clk);
        f1 = {8'hAB};
        push_frame(f1, 64, -1, 1'b0, 32'd0);
        drive_frame(f1, -1, 1'b0);
        wait_idle("t2");
        check_len("t2_txen_len", 72);
        check("t2_done", 32'(done_cnt), 32'd2);

        f1.delete();
        for (int i = 0; i < 60; i++) f1.push_back(8'($urandom_range(0, 255)));
        push_frame(f1, 64, -1, 1'b0, 32'd0);
        drive_frame(f1, -1, 1'b0);
        wait_idle("t3");
        check_len("t3_txen_len", 72);
        check("t3_done", 32'(done_cnt), 32'd3);

        // Back-to-back with in_valid held high.
        f2.delete();
        for (int i = 0; i < 10; i++) f2.push_back(8'($urandom_range(0, 255)));
        push_frame(f1, 64, -1, 1'b0, 32'd0);
        push_frame(f2, 64, -1, 1'b0, 32'd0);
        drive_frame(f1, -1, 1'b1);
        drive_frame(f2, -1, 1'b0);
        wait_idle("t4");
        check_len("t4_len_first", 72);
        check_len("t4_len_second", 72);
        check("t4_gap", 32'(gap_last), 32'd12);
        check("t4_done", 32'(done_cnt), 32'd5);

        // Underrun after 20 data bytes of a 100-byte frame.
        f1.delete();
        for (int i = 0; i < 100; i++) f1.push_back(8'($urandom_range(0, 255)));
        push_frame(f1, 64, 20, 1'b0, 32'd0);
        drive_frame(f1, 20, 1'b0);
        wait_idle("t5");
        check_len("t5_txen_len", 29);
        check("t5_abort", 32'(abort_cnt), 32'd1);
        check("t5_done_unchanged", 32'(done_cnt), 32'd5);
        f2 = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        push_frame(f2, 64, -1, 1'b0, 32'd0);
        drive_frame(f2, -1, 1'b0);
        wait_idle("t5b");
        check_len("t5b_txen_len", 72);
        check("t5b_gap_ok", 32'(gap_last >= 12), 32'd1);
        check("t5b_done", 32'(done_cnt), 32'd6);

        // Reset while padding.
        f1 = {8'hCD};
        push_frame(f1, 64, -1, 1'b0, 32'd0);
        drive_frame(f1, -1, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_in_pad", {23'd0, mon_txen, mon_txd}, 32'h100);
        #2 rst_n = 1'b0;
        #1 check("t6_async_txen", {23'd0, mon_txen, mon_txd}, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        len_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_done", 32'(done_cnt), 32'd6);
        f2 = {8'h01, 8'h02, 8'h03};
        push_frame(f2, 64, -1, 1'b0, 32'd0);
        drive_frame(f2, -1, 1'b0);
        wait_idle("t6b");
        check_len("t6b_txen_len", 72);
        check("t6b_done", 32'(done_cnt), 32'd7);
        check("final_abort", 32'(abort_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
Parametrised transmit MAC for the ethernet block, the successor to the fixed transmitter path. It accepts a byte stream (dest MAC, src MAC, EtherType, payload) from the LLC side over a valid/ready/last handshake. It emits GMII-style txen/txd/txer with preamble/SFD insertion, zero padding to the minimum frame size, CRC-32 FCS append, a configurable inter-frame gap, and underrun/oversize abort.

Parameters:
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD (1..15)
MIN_FRAME_BYTES, 64, minimum frame incl. FCS; data+pad extended to MIN_FRAME_BYTES-4; 0 disables padding
MAX_FRAME_BYTES, 1518, maximum frame incl. FCS; data beyond MAX_FRAME_BYTES-4 is an oversize abort
IFG_BYTES, 12, minimum idle cycles (txen low) between frames (>=1)
FCS_EN, 1, 1 appends FCS; 0 omits FCS and padding target becomes MIN_FRAME_BYTES

Ports:
in_txc  input  1  transmit clock, all logic rising-edge
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream byte valid
in_data  input  8  upstream byte
in_last  input  1  marks final byte of frame
out_ready  output  1  byte accepted when in_valid & out_ready
out_txen  output  1  GMII transmit enable
out_txd  output  8  GMII transmit data
out_txer  output  1  GMII transmit error
out_frame_done  output  1  one-cycle pulse, frame completed cleanly
out_abort  output  1  one-cycle pulse, frame aborted (underrun or oversize)

Behaviour:
- Reset (async assert, sync deassert by design): state IDLE. out_txen=0, out_txd=0x00, out_txer=0, out_ready=0, pulses 0. Counters and CRC are cleared; CRC is preset to 0xFFFFFFFF at each SFD.
- Reset mid-frame: outputs drop to reset values immediately. No FCS and no IFG follow. After reset, the IFG requirement is satisfied.
- All txen/txd/txer outputs are registered. out_ready is combinational from state: high only in DATA and DRAIN.
- States:
  - IDLE: if in_valid, go to PRE. First 0x55 appears on out_txd the following cycle.
  - PRE: PREAMBLE_BYTES cycles of 0x55 with txen=1.
  - SFD: one cycle of 0xD5.
  - DATA: each accepted byte appears on out_txd one cycle after acceptance and feeds the CRC. The byte count increments per accepted byte.
    - Accepted in_last with count+1 < pad target: go to PAD.
    - Accepted in_last otherwise: go to FCS (or IFG if FCS_EN=0).
    - in_valid=0 in DATA (underrun): out_txer=1, txen=1, txd=0x00 for one cycle, pulse out_abort. If that cycle did not see in_last, go to DRAIN; otherwise go to IFG.
    - Accepting a byte that would make count exceed MAX_FRAME_BYTES-4 (oversize): the byte is not transmitted. Handle as underrun: txer cycle, then DRAIN unless that byte had in_last.
  - PAD: txd=0x00, fed to CRC, until count = pad target.
  - FCS: 4 bytes, complemented CRC, LSB byte first. The last FCS byte's cycle sets out_frame_done on the next cycle together with entry to IFG.
  - DRAIN: txen=0, out_ready=1. Bytes are discarded until in_last is accepted, then go to IFG. Drain cycles count toward the IFG.
  - IFG: txen=0 for at least IFG_BYTES cycles, then IDLE. in_valid during IFG waits and is not accepted.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, init 0xFFFFFFFF, 1 byte/cycle, final XOR 0xFFFFFFFF.
- Byte counter width: clog2(MAX_FRAME_BYTES+1). It never wraps: the oversize check fires first.
- Back-to-back frames: the next preamble starts exactly IFG_BYTES+1 cycles after the last FCS byte when in_valid is held high.

Decomposition:
- Package mac_pkg holds the state enum, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, FCS_BYTES=4.
- One sub-module, crc32_d8: combinational next-CRC from current CRC and data byte, shared later by the receiver's FCS check.

Test Plan:
- MIN_FRAME_BYTES=0, frame "123456789" (0x31..0x39), no stalls -> 7×0x55, 0xD5, 9 data bytes, then FCS 0x26,0x39,0xF4,0xCB; txen high 21 cycles; out_frame_done pulses once.
- Defaults, 1-byte frame 0xAB with last -> 0xAB, then 59×0x00 pad, then 4 FCS bytes matching the software model; txen high 72 cycles.
- Defaults, 60-byte frame -> no pad cycles, FCS immediately follows byte 60; txen high 72 cycles.
- Two frames back-to-back with in_valid held high -> exactly 12 txen-low cycles between the last FCS byte and the next 0x55.
- Underrun: in_valid dropped after 20 data bytes of a 100-byte frame -> one cycle txen=1, txer=1, txd=0x00; out_abort pulse; remaining 80 bytes drained with txen=0; no FCS; next frame starts after the IFG.
- Reset asserted during PAD -> txen=0 within the same cycle (async); after release, a new frame starts with a full preamble and correct FCS.
